program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: streams instruction words from an upstream valid/ready source into the
// instruction memory one word at a time, then releases the core once the final word is
// acknowledged. Overflow or a missing memory acknowledge latches a sticky error and parks
// the loader until reset.
module program_loader #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              mem_request,
   output logic              mem_we_re,
   output logic [3:0]        mem_mask,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_wdata,
   input  logic              mem_valid,
   output logic              core_enable,
   output logic [ADDR_W:0]   word_count,
   output logic              load_err
);

   // Wait counter holds "cycles since the write request", so it must reach ACK_TIMEOUT.
   localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

   // word_count value meaning every address has been written.
   localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

   // Last WAIT_ACK cycle in which an acknowledge is still honoured; ERROR is then
   // entered ACK_TIMEOUT cycles after the request cycle.
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWrite   = 3'd1,
      StWaitAck = 3'd2,
      StDone    = 3'd3,
      StError   = 3'd4
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic [WAIT_W-1:0]   wait_cnt_q;
   logic [31:0]         data_q;
   logic                last_q;

   // The pointer and the captured word drive the memory bus directly; only the
   // request/strobe lines need to be qualified by state.
   assign mem_address = ptr_q;
   assign mem_wdata   = data_q;

   // Single-process FSM: every output is a register updated together with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         word_count  <= '0;
         wait_cnt_q  <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
         load_err    <= 1'b0;
         core_enable <= 1'b0;
         mem_request <= 1'b0;
         mem_we_re   <= 1'b0;
         mem_mask    <= 4'b0000;
         s_ready     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (s_valid && s_ready) begin
                  s_ready <= 1'b0;
                  if (word_count == FULL_COUNT) begin
                     // Memory already full: drop the word without touching the bus.
                     state_q  <= StError;
                     load_err <= 1'b1;
                  end else begin
                     state_q     <= StWrite;
                     data_q      <= s_data;
                     last_q      <= s_last;
                     mem_request <= 1'b1;
                     mem_we_re   <= 1'b1;
                     mem_mask    <= 4'b1111;
                  end
               end else begin
                  // Also raises s_ready on the first edge after reset release.
                  s_ready <= 1'b1;
               end
            end

            StWrite: begin
               state_q     <= StWaitAck;
               mem_request <= 1'b0;
               mem_we_re   <= 1'b0;
               mem_mask    <= 4'b0000;
               wait_cnt_q  <= WAIT_W'(1);
            end

            StWaitAck: begin
               if (mem_valid) begin
                  ptr_q      <= ptr_q + ADDR_W'(1);
                  word_count <= word_count + (ADDR_W + 1)'(1);
                  wait_cnt_q <= '0;
                  if (last_q) begin
                     state_q     <= StDone;
                     core_enable <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     s_ready <= 1'b1;
                  end
               end else if (wait_cnt_q >= WAIT_LIMIT) begin
                  // Acknowledge never came: the word is not counted.
                  state_q    <= StError;
                  load_err   <= 1'b1;
                  wait_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end

            StDone: begin
               core_enable <= 1'b1;
               s_ready     <= 1'b0;
            end

            StError: begin
               load_err    <= 1'b1;
               core_enable <= 1'b0;
               s_ready     <= 1'b0;
            end

            default: begin
               state_q  <= StError;
               load_err <= 1'b1;
               s_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Two instances share the stream/memory stimulus: an
// ADDR_W=8 part for the main scenarios and an ADDR_W=2 part for the overflow cases; the
// unused one is held in reset. Inputs change and outputs are sampled on the falling edge.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        s_valid, s_last, mem_valid;
   logic [31:0] s_data;

   logic        a_ready, a_req, a_we, a_en, a_err;
   logic [3:0]  a_mask;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_cnt;

   logic        b_ready, b_req, b_we, b_en, b_err;
   logic [3:0]  b_mask;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_cnt;

   logic        use_b;
   logic        o_ready, o_req, o_we, o_en, o_err;
   logic [3:0]  o_mask;
   logic [7:0]  o_addr;
   logic [31:0] o_wdata;
   logic [8:0]  o_cnt;

   int n_cmp = 0;
   int n_err = 0;

   program_loader #(.ADDR_W(8), .ACK_TIMEOUT(15)) dut_a (
      .clk(clk), .rst(rst_a), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(a_ready), .mem_request(a_req), .mem_we_re(a_we), .mem_mask(a_mask),
      .mem_address(a_addr), .mem_wdata(a_wdata), .mem_valid(mem_valid),
      .core_enable(a_en), .word_count(a_cnt), .load_err(a_err)
   );

   program_loader #(.ADDR_W(2), .ACK_TIMEOUT(15)) dut_b (
      .clk(clk), .rst(rst_b), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(b_ready), .mem_request(b_req), .mem_we_re(b_we), .mem_mask(b_mask),
      .mem_address(b_addr), .mem_wdata(b_wdata), .mem_valid(mem_valid),
      .core_enable(b_en), .word_count(b_cnt), .load_err(b_err)
   );

   always #5 clk = ~clk;

   // Observe whichever instance is under test.
   always_comb begin
      o_ready = use_b ? b_ready : a_ready;
      o_req   = use_b ? b_req   : a_req;
      o_we    = use_b ? b_we    : a_we;
      o_mask  = use_b ? b_mask  : a_mask;
      o_addr  = use_b ? {6'b0, b_addr} : a_addr;
      o_wdata = use_b ? b_wdata : a_wdata;
      o_en    = use_b ? b_en    : a_en;
      o_err   = use_b ? b_err   : a_err;
      o_cnt   = use_b ? {6'b0, b_cnt} : a_cnt;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Pulse reset on the selected instance; leaves the other one held in reset.
   task automatic do_reset();
      rst_a = 1'b0;
      rst_b = 1'b0;
      step();
      rst_a = !use_b;
      rst_b = use_b;
      step();
   endtask

   // Push one word; mem_valid is raised in WAIT_ACK cycle (dly+1) after the request.
   task automatic send(input logic [31:0] d, input logic l, input int dly, input int addr);
      int n;
      n = 0;
      while (!o_ready && n < 10) begin
         step();
         n++;
      end
      check("ready_before_accept", o_ready, 1);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("wr_request", o_req, 1);
      check("wr_we", o_we, 1);
      check("wr_mask", o_mask, 4'hf);
      check("wr_addr", o_addr, addr);
      check("wr_data", o_wdata, d);
      check("wr_ready_low", o_ready, 0);
      step();
      repeat (dly) begin
         check("ack_wait_req_low", o_req, 0);
         check("ack_wait_mask_low", o_mask, 0);
         step();
      end
      check("pre_ack_enable_low", o_en, 0);
      mem_valid = 1'b1;
      step();
      mem_valid = 1'b0;
   endtask

   logic [31:0] words [5];
   logic [11:0] pat;
   logic        rdy;
   int          acc, wr;

   initial begin
      rst_a     = 1'b0;
      rst_b     = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_data    = '0;
      mem_valid = 1'b0;
      use_b     = 1'b0;
      step();
      step();

      // Reset state.
      check("rst_ready", o_ready, 0);
      check("rst_request", o_req, 0);
      check("rst_mask", o_mask, 0);
      check("rst_addr", o_addr, 0);
      check("rst_wdata", o_wdata, 0);
      check("rst_count", o_cnt, 0);
      check("rst_err", o_err, 0);
      check("rst_enable", o_en, 0);
      rst_a = 1'b1;
      #1 check("ready_before_first_edge", o_ready, 0);
      step();
      check("ready_after_first_edge", o_ready, 1);

      // Three-word program, immediate acknowledges.
      send(32'h00000013, 1'b0, 0, 0);
      send(32'h00100093, 1'b0, 0, 1);
      send(32'h00208113, 1'b1, 0, 2);
      check("prog3_count", o_cnt, 3);
      check("prog3_enable", o_en, 1);
      check("prog3_err", o_err, 0);
      check("prog3_ready_low", o_ready, 0);
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      check("done_ignores_input", o_req, 0);

      // Single word with a late acknowledge: DONE five cycles after the request.
      do_reset();
      send(32'hDEADBEEF, 1'b1, 3, 0);
      check("late_ack_enable", o_en, 1);
      check("late_ack_count", o_cnt, 1);
      check("late_ack_err", o_err, 0);

      // No acknowledge: ERROR exactly 15 cycles after the request.
      do_reset();
      s_valid = 1'b1;
      s_data  = 32'h12345678;
      step();
      s_valid = 1'b0;
      check("to_request", o_req, 1);
      repeat (14) step();
      check("to_err_cycle14", o_err, 0);
      step();
      check("to_err_cycle15", o_err, 1);
      check("to_enable", o_en, 0);
      check("to_count", o_cnt, 0);
      check("to_ready", o_ready, 0);
      mem_valid = 1'b1;
      step();
      step();
      mem_valid = 1'b0;
      check("to_sticky_err", o_err, 1);
      check("to_late_ack_ignored", o_cnt, 0);

      // Reset during WAIT_ACK of the second word.
      do_reset();
      send(32'hAAAA0001, 1'b0, 0, 0);
      s_valid = 1'b1;
      s_data  = 32'hAAAA0002;
      step();
      s_valid = 1'b0;
      step();
      check("abort_pre_addr", o_addr, 1);
      #2 rst_a = 1'b0;
      #1;
      check("abort_ready", o_ready, 0);
      check("abort_request", o_req, 0);
      check("abort_addr", o_addr, 0);
      check("abort_wdata", o_wdata, 0);
      check("abort_count", o_cnt, 0);
      check("abort_err", o_err, 0);
      check("abort_enable", o_en, 0);
      step();
      rst_a = 1'b1;
      step();
      send(32'hAAAA0003, 1'b1, 0, 0);
      check("reload_count", o_cnt, 1);
      check("reload_enable", o_en, 1);

      // Streaming with s_valid held high and mem_valid always high.
      words[0] = 32'h11110000;
      words[1] = 32'h22221111;
      words[2] = 32'h33332222;
      words[3] = 32'h44443333;
      words[4] = 32'h55554444;
      do_reset();
      mem_valid = 1'b1;
      s_valid   = 1'b1;
      s_data    = words[0];
      s_last    = 1'b0;
      acc = 0;
      wr  = 0;
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         if (o_req) begin
            check("stream_wdata", o_wdata, words[wr]);
            check("stream_addr", o_addr, wr);
            wr++;
         end
         pat[i] = o_ready;
         rdy = o_ready;
         step();
         if (rdy) begin
            acc++;
            s_data = words[acc];
            s_last = (acc == 3);
         end
      end
      s_valid   = 1'b0;
      s_last    = 1'b0;
      mem_valid = 1'b0;
      check("stream_ready_pattern", pat, 12'h249);
      check("stream_writes", wr, 4);
      check("stream_enable", o_en, 1);
      check("stream_count", o_cnt, 4);

      // ADDR_W=2: fill all four addresses, then overflow on a fifth word.
      use_b = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) send(32'hB0000000 + i, 1'b0, 0, i);
      check("full_count", o_cnt, 4);
      check("full_err", o_err, 0);
      check("full_ready", o_ready, 1);
      s_valid = 1'b1;
      s_data  = 32'hB0000004;
      step();
      s_valid = 1'b0;
      check("ovf_no_write", o_req, 0);
      check("ovf_err", o_err, 1);
      check("ovf_count", o_cnt, 4);
      check("ovf_ready", o_ready, 0);
      step();
      check("ovf_still_no_write", o_req, 0);

      // ADDR_W=2: s_last on the word filling the last address completes normally.
      do_reset();
      for (int i = 0; i < 4; i++) send(32'hC0000000 + i, (i == 3), 0, i);
      check("fill_last_enable", o_en, 1);
      check("fill_last_err", o_err, 0);
      check("fill_last_count", o_cnt, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
